// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_adder_pkg : shared state encoding and default width for the adder
// Revision 1.0
// ---------------------------------------------------------------------------
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

endpackage
`default_nettype wire

// File: rtl/full_adder_cell.sv
`default_nettype none
// ---------------------------------------------------------------------------
// full_adder_cell : single-bit combinational full adder
// Revision 1.0
// ---------------------------------------------------------------------------
module full_adder_cell (
  input  logic x_i,
  input  logic y_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = x_i ^ y_i ^ ci_i;
  assign co_o = (x_i & y_i) | (ci_i & (x_i ^ y_i));

endmodule
`default_nettype wire

// File: rtl/serial_adder_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_adder_fsm : bit-serial WIDTH-bit adder/subtractor, LSB first
// Revision 1.0
// ---------------------------------------------------------------------------
module serial_adder_fsm
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             overflow_o
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PEN  = CW'(WIDTH - 2);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cinm_q, cinm_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             w_s;
  logic             w_co;

  full_adder_cell u_fa (
    .x_i  (opa_q[0]),
    .y_i  (opb_q[0]),
    .ci_i (carry_q),
    .s_o  (w_s),
    .co_o (w_co)
  );

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cinm_d  = cinm_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
          opa_d   = a_i;
          opb_d   = sub_i ? ~b_i : b_i;
          carry_d = sub_i;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_d   = {w_s, res_q[WIDTH-1:1]};
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        carry_d = w_co;
        if (cnt_q == CNT_PEN) begin
          cinm_d = w_co;
        end
        if (cnt_q == CNT_LAST) begin
          sum_d   = {w_s, res_q[WIDTH-1:1]};
          cout_d  = w_co;
          ovf_d   = cinm_q ^ w_co;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cinm_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cinm_q  <= cinm_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o     = (state_q == S_RUN) || (state_q == S_DONE);
  assign done_o     = (state_q == S_DONE);
  assign sum_o      = sum_q;
  assign cout_o     = cout_q;
  assign overflow_o = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_serial_adder_fsm : scoreboard bench for 8- and 16-bit serial adders
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_serial_adder_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_s [2];
  logic        sub_s   [2];
  logic [31:0] a_s     [2];
  logic [31:0] b_s     [2];
  logic        busy_w  [2];
  logic        done_w  [2];
  logic        cout_w  [2];
  logic        ovf_w   [2];
  logic [31:0] sum_w   [2];
  logic [7:0]  sum8;
  logic [15:0] sum16;
  logic        prev_done [2];

  int          wid [2] = '{8, 16};
  logic [33:0] q0 [$];
  logic [33:0] q1 [$];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  assign sum_w[0] = {24'd0, sum8};
  assign sum_w[1] = {16'd0, sum16};

  serial_adder_fsm #(.WIDTH(8)) u_dut8 (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start_s[0]),
    .sub_i      (sub_s[0]),
    .a_i        (a_s[0][7:0]),
    .b_i        (b_s[0][7:0]),
    .busy_o     (busy_w[0]),
    .done_o     (done_w[0]),
    .sum_o      (sum8),
    .cout_o     (cout_w[0]),
    .overflow_o (ovf_w[0])
  );

  serial_adder_fsm #(.WIDTH(16)) u_dut16 (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start_s[1]),
    .sub_i      (sub_s[1]),
    .a_i        (a_s[1][15:0]),
    .b_i        (b_s[1][15:0]),
    .busy_o     (busy_w[1]),
    .done_o     (done_w[1]),
    .sum_o      (sum16),
    .cout_o     (cout_w[1]),
    .overflow_o (ovf_w[1])
  );

  // Reference: signed/unsigned arithmetic on integers, packed {ovf, cout, sum}.
  function automatic logic [33:0] model(input int w, input logic s,
                                        input logic [31:0] av, input logic [31:0] bv);
    longint m, half, ua, ub, full, sa, sb, r;
    logic   ov, co;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(av) & m;
    ub   = longint'(bv) & m;
    full = s ? (ua + ((~ub) & m) + 1) : (ua + ub);
    co   = ((full >> w) & 1) != 0;
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sb   = (ub >= half) ? ub - 2 * half : ub;
    r    = s ? (sa - sb) : (sa + sb);
    ov   = (r >= half) || (r < -half);
    return {ov, co, 32'(full & m)};
  endfunction

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: actual=timeout expected=event", nm);
  endtask

  function automatic logic [39:0] result(input int k);
    return {6'd0, ovf_w[k], cout_w[k], sum_w[k]};
  endfunction

  always @(negedge clk) begin
    logic [33:0] e;
    for (int k = 0; k < 2; k++) begin
      if (done_w[k]) begin
        chk("done_single_pulse", {39'd0, prev_done[k]}, 40'd0);
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
          timeout("unexpected_done");
        end else begin
          if (k == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk(k == 0 ? "result_w8" : "result_w16", result(k), {6'd0, e});
        end
      end
      prev_done[k] = done_w[k];
    end
  end

  task automatic issue(input int k, input logic s, input logic [31:0] av,
                       input logic [31:0] bv, input bit push);
    @(negedge clk);
    for (int i = 0; i < 64 && busy_w[k]; i++) @(negedge clk);
    if (busy_w[k]) timeout("wait_idle");
    start_s[k] = 1'b1;
    sub_s[k]   = s;
    a_s[k]     = av;
    b_s[k]     = bv;
    if (push) begin
      if (k == 0) q0.push_back(model(wid[k], s, av, bv));
      else        q1.push_back(model(wid[k], s, av, bv));
    end
    @(posedge clk);
    #1;
    start_s[k] = 1'b0;
    sub_s[k]   = 1'($urandom);
    a_s[k]     = $urandom;
    b_s[k]     = $urandom;
  endtask

  // Returns at the negedge where done is seen; noise drives ignored starts.
  task automatic wait_done(input int k, input bit noise);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (done_w[k]) begin
        got = 1'b1;
        start_s[k] = 1'b0;
      end else if (noise) begin
        start_s[k] = 1'($urandom);
        sub_s[k]   = 1'($urandom);
        a_s[k]     = $urandom;
        b_s[k]     = $urandom;
      end
    end
    start_s[k] = 1'b0;
    if (!got) timeout("wait_done");
  endtask

  task automatic directed(input string nm, input logic s, input logic [31:0] av,
                          input logic [31:0] bv, input logic [33:0] exp);
    issue(0, s, av, bv, 1'b1);
    wait_done(0, 1'b0);
    chk(nm, result(0), {6'd0, exp});
  endtask

  initial begin
    int n, bc;
    bit got;
    logic [31:0] av, bv, m;
    for (int k = 0; k < 2; k++) begin
      start_s[k] = 1'b0; sub_s[k] = 1'b0; a_s[k] = '0; b_s[k] = '0;
      prev_done[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++)
      chk("reset_state", {busy_w[k], done_w[k], 4'd0, ovf_w[k], cout_w[k], sum_w[k]}, 40'd0);

    // First add with latency and busy-length measurement.
    issue(0, 1'b0, 32'h3C, 32'h05, 1'b1);
    n = 0; bc = 0; got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      n++;
      if (busy_w[0]) bc++;
      if (done_w[0]) got = 1'b1;
    end
    if (!got) timeout("first_done");
    chk("add_3C_05", result(0), {6'd0, 2'b00, 32'h41});
    chk("latency", 40'(n), 40'(9));
    chk("busy_cycles", 40'(bc), 40'(9));
    @(negedge clk);
    chk("idle_after_done", {38'd0, busy_w[0], done_w[0]}, 40'd0);

    directed("add_FF_01", 1'b0, 32'hFF, 32'h01, {2'b01, 32'h00});
    directed("add_7F_01", 1'b0, 32'h7F, 32'h01, {2'b10, 32'h80});
    directed("sub_05_07", 1'b1, 32'h05, 32'h07, {2'b00, 32'hFE});
    directed("sub_80_01", 1'b1, 32'h80, 32'h01, {2'b11, 32'h7F});

    // start held high with operands scrambled during RUN.
    @(negedge clk);
    for (int i = 0; i < 64 && busy_w[0]; i++) @(negedge clk);
    start_s[0] = 1'b1; sub_s[0] = 1'b0; a_s[0] = 32'h11; b_s[0] = 32'h22;
    q0.push_back(model(8, 1'b0, 32'h11, 32'h22));
    @(posedge clk);
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (done_w[0]) got = 1'b1;
      else begin
        a_s[0] = $urandom; b_s[0] = $urandom; sub_s[0] = 1'($urandom);
      end
    end
    if (!got) timeout("held_first_done");
    chk("held_first", result(0), {6'd0, 2'b00, 32'h33});
    sub_s[0] = 1'b0; a_s[0] = 32'h40; b_s[0] = 32'h02;
    q0.push_back(model(8, 1'b0, 32'h40, 32'h02));
    @(negedge clk);
    chk("gap_idle", {39'd0, busy_w[0]}, 40'd0);
    @(negedge clk);
    chk("accept_after_done", {39'd0, busy_w[0]}, 40'd1);
    start_s[0] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      if (done_w[0]) got = 1'b1;
      else begin
        chk("sum_held_in_run", result(0), {6'd0, 2'b00, 32'h33});
        @(negedge clk);
      end
    end
    if (!got) timeout("held_second_done");
    chk("held_second", result(0), {6'd0, 2'b00, 32'h42});

    // Reset in RUN cycle 4 discards the operation.
    issue(0, 1'b0, 32'h12, 32'h34, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_mid_run", {busy_w[0], done_w[0], 4'd0, ovf_w[0], cout_w[0], sum_w[0]}, 40'd0);
    directed("after_reset_1p1", 1'b0, 32'h1, 32'h1, {2'b00, 32'h02});

    for (int k = 0; k < 2; k++) begin
      m = (wid[k] == 8) ? 32'hFF : 32'hFFFF;
      for (int i = 0; i < 1000; i++) begin
        case ($urandom % 4)
          0:       av = m;
          1:       av = (m >> 1) + 1;
          default: av = $urandom & m;
        endcase
        bv = ($urandom % 5 == 0) ? ((m >> 1) + 1) : ($urandom & m);
        issue(k, 1'($urandom), av, bv, 1'b1);
        wait_done(k, 1'b1);
      end
    end

    repeat (3) @(negedge clk);
    chk("queue_empty_w8", 40'(q0.size()), 40'd0);
    chk("queue_empty_w16", 40'(q1.size()), 40'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
